count_hold_add: RTL and testbench

//   Small 4-bit datapath register with three modes picked by sel.
//   - Free-running up-counter.
//   - Hold (freeze).
//   - Registered adder of two 3-bit operands.

---
 rtl/count_hold_add.sv | 42 ++++
 tb/tb_count_hold_add.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/count_hold_add.sv
// 4-bit datapath register: free-running counter, hold, or registered
// sum of two 3-bit operands, selected per cycle by sel.
module count_hold_add (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [3:0] dout
);

    localparam logic [1:0] SEL_ADD   = 2'b00;
    localparam logic [1:0] SEL_HOLD  = 2'b01;
    localparam logic [1:0] SEL_COUNT = 2'b10;
    localparam logic [1:0] SEL_HOLD2 = 2'b11;

    logic [3:0] sum;
    logic [3:0] next;

    // Zero-extend before adding so 7+7 fits in the 4-bit result.
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        next = dout;
        unique case (sel)
            SEL_ADD:   next = sum;
            SEL_COUNT: next = dout + 4'd1;
            SEL_HOLD:  next = dout;
            SEL_HOLD2: next = dout;
            default:   next = dout;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 4'd0;
        end else begin
            dout <= next;
        end
    end

endmodule

// File: tb/tb_count_hold_add.sv
// Directed self-checking bench for count_hold_add.
// Inputs change 1 ns after the rising edge; outputs are read there too.
module tb_count_hold_add;

    logic       clk;
    logic       rst;
    logic [1:0] sel;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] dout;

    int total;
    int bad;

    count_hold_add dut (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .a    (a),
        .b    (b),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel = 2'b10;
        a   = 3'd0;
        b   = 3'd0;
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (dout !== 4'd0) begin
            bad++;
            $display("FAIL reset_async got=%0d want=0", dout);
        end
        step();
        step();
        total++;
        if (dout !== 4'd0) begin
            bad++;
            $display("FAIL reset_held got=%0d want=0", dout);
        end
        sel = 2'b00;
        #2;
        rst = 1'b1;
        step();
        total++;
        if (dout !== 4'd0) begin
            bad++;
            $display("FAIL reset_release got=%0d want=0", dout);
        end
    endtask

    task automatic test_count();
        sel = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (dout !== 4'(i)) begin
                bad++;
                $display("FAIL count_step%0d got=%0d want=%0d", i, dout, i);
            end
        end
    endtask

    task automatic test_hold();
        sel = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (dout !== 4'd8) begin
                bad++;
                $display("FAIL hold01 got=%0d want=8", dout);
            end
        end
        sel = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (dout !== 4'd8) begin
                bad++;
                $display("FAIL hold11 got=%0d want=8", dout);
            end
        end
        sel = 2'b10;
        step();
        total++;
        if (dout !== 4'd9) begin
            bad++;
            $display("FAIL hold_resume got=%0d want=9", dout);
        end
    endtask

    task automatic test_add();
        sel = 2'b00;
        a   = 3'd3;
        b   = 3'd4;
        step();
        total++;
        if (dout !== 4'd7) begin
            bad++;
            $display("FAIL add_3_4 got=%0d want=7", dout);
        end
        a = 3'd1;
        b = 3'd5;
        step();
        total++;
        if (dout !== 4'd6) begin
            bad++;
            $display("FAIL add_1_5 got=%0d want=6", dout);
        end
        a = 3'd7;
        b = 3'd0;
        #2;
        a = 3'd2;
        b = 3'd2;
        step();
        total++;
        if (dout !== 4'd4) begin
            bad++;
            $display("FAIL add_midcycle got=%0d want=4", dout);
        end
    endtask

    task automatic test_wrap();
        sel = 2'b00;
        a   = 3'd0;
        b   = 3'd0;
        step();
        total++;
        if (dout !== 4'd0) begin
            bad++;
            $display("FAIL add_0_0 got=%0d want=0", dout);
        end
        sel = 2'b10;
        for (int i = 1; i <= 17; i++) begin
            step();
            total++;
            if (dout !== 4'(i % 16)) begin
                bad++;
                $display("FAIL wrap_step%0d got=%0d want=%0d",
                         i, dout, i % 16);
            end
        end
        sel = 2'b00;
        a   = 3'd7;
        b   = 3'd7;
        step();
        total++;
        if (dout !== 4'd14) begin
            bad++;
            $display("FAIL add_7_7 got=%0d want=14", dout);
        end
        sel = 2'b10;
        step();
        total++;
        if (dout !== 4'd15) begin
            bad++;
            $display("FAIL add_then_count got=%0d want=15", dout);
        end
    endtask

    task automatic test_async_reset();
        sel = 2'b00;
        a   = 3'd0;
        b   = 3'd0;
        step();
        sel = 2'b10;
        for (int i = 0; i < 5; i++) step();
        total++;
        if (dout !== 4'd5) begin
            bad++;
            $display("FAIL pre_reset_count got=%0d want=5", dout);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (dout !== 4'd0) begin
            bad++;
            $display("FAIL midop_reset got=%0d want=0", dout);
        end
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            total++;
            if (dout !== 4'(i)) begin
                bad++;
                $display("FAIL post_reset_count%0d got=%0d want=%0d",
                         i, dout, i);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_count();
        test_hold();
        test_add();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
